// File: rtl/uop_sequencer.sv
// uop_sequencer: decode-front micro-op sequencer.
// Cracks jap / lwm / swm into plain single-cycle MIPS instructions.
// Every other instruction passes through as a single micro-op.
module uop_sequencer #(
  parameter logic [5:0]  OP_JAP    = 6'b111100,
  parameter logic [5:0]  OP_LWM    = 6'b111101,
  parameter logic [5:0]  OP_SWM    = 6'b111110,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        uop_valid,
  input  logic        uop_ready,
  output logic [31:0] uop_instr,
  output logic [31:0] uop_pc,
  output logic [4:0]  uop_idx,
  output logic        uop_last
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEQ  = 1'b1;

  localparam logic [4:0]  MAX_N    = 5'(MAX_BURST);
  localparam logic [5:0]  OPC_LW   = 6'b100011;
  localparam logic [5:0]  OPC_SW   = 6'b101011;
  localparam logic [5:0]  OPC_J    = 6'b000010;
  localparam logic [31:0] JAP_PUSH = 32'hAFBF0000;  // sw $31,0($29)
  localparam logic [31:0] JAP_ADJ  = 32'h27BDFFFC;  // addiu $29,$29,-4

  logic [0:0]  state;
  logic [31:0] parent_q;  // captured parent instruction (holds base/first fields)
  logic [4:0]  count_q;   // micro-op count N of the parent (0 means single nop)

  logic        accept;
  logic        advance;
  logic        consume;
  logic [4:0]  next_idx;

  // Number of micro-ops a parent cracks into (lwm/swm clamped to MAX_BURST).
  function automatic logic [4:0] uop_count(input logic [31:0] ins);
    logic [5:0] opc;
    logic [4:0] cnt;
    opc = ins[31:26];
    cnt = ins[10:6];
    if (opc == OP_JAP)
      return 5'd3;
    else if (opc == OP_LWM || opc == OP_SWM)
      return (cnt > MAX_N) ? MAX_N : cnt;
    else
      return 5'd1;
  endfunction

  // Micro-op word number idx of parent ins.
  function automatic logic [31:0] uop_word(input logic [31:0] ins, input logic [4:0] idx);
    logic [5:0] opc;
    logic [5:0] mem_opc;
    opc     = ins[31:26];
    mem_opc = (opc == OP_LWM) ? OPC_LW : OPC_SW;
    if (opc == OP_JAP) begin
      if (idx == 5'd0)      return JAP_PUSH;
      else if (idx == 5'd1) return JAP_ADJ;
      else                  return {OPC_J, ins[25:0]};
    end else if (opc == OP_LWM || opc == OP_SWM) begin
      if (ins[10:6] == 5'd0)
        return '0;
      else
        return {mem_opc, ins[25:21], 5'(ins[20:16] + idx), 9'd0, idx, 2'b00};
    end else begin
      return ins;
    end
  endfunction

  // A zero count still yields exactly one (nop) micro-op, which is last.
  function automatic logic is_last(input logic [4:0] count, input logic [4:0] idx);
    return (count == 5'd0) || (idx == count - 5'd1);
  endfunction

  assign uop_valid = (state == SEQ);

  // Handshake decode for both sides.
  always_comb begin
    in_ready = !flush && (!uop_valid || (uop_ready && uop_last));
    accept   = in_valid && in_ready;
    consume  = uop_valid && uop_ready;
    advance  = consume && !uop_last;
    next_idx = uop_idx + 5'd1;
  end

  // Sequencer state and output register; flush outranks accept and advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      parent_q  <= '0;
      count_q   <= '0;
      uop_instr <= '0;
      uop_pc    <= '0;
      uop_idx   <= '0;
      uop_last  <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      state     <= SEQ;
      parent_q  <= in_instr;
      count_q   <= uop_count(in_instr);
      uop_instr <= uop_word(in_instr, 5'd0);
      uop_pc    <= in_pc;
      uop_idx   <= '0;
      uop_last  <= is_last(uop_count(in_instr), 5'd0);
    end else if (advance) begin
      uop_instr <= uop_word(parent_q, next_idx);
      uop_idx   <= next_idx;
      uop_last  <= is_last(count_q, next_idx);
    end else if (consume) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_uop_sequencer.sv
// Self-checking bench for uop_sequencer: expands each accepted parent into
// its full micro-op list and compares the DUT against that list every cycle.
module tb_uop_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        uop_valid;
  logic        uop_ready;
  logic [31:0] uop_instr;
  logic [31:0] uop_pc;
  logic [4:0]  uop_idx;
  logic        uop_last;

  uop_sequencer #(.MAX_BURST(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .uop_valid (uop_valid),
    .uop_ready (uop_ready),
    .uop_instr (uop_instr),
    .uop_pc    (uop_pc),
    .uop_idx   (uop_idx),
    .uop_last  (uop_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [4:0]  idx;
    logic        last;
  } uop_t;

  uop_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic last_ir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference expansion of one parent instruction into its micro-op list.
  function automatic void expand(input logic [31:0] ins, input logic [31:0] pc);
    uop_t u;
    int   n;
    int   cnt;
    logic [5:0] op;
    u.pc = pc;
    op   = ins[31:26];
    if (op == 6'b111100) begin
      u.idx = 0; u.last = 0; u.instr = 32'hAFBF0000; q.push_back(u);
      u.idx = 1; u.last = 0; u.instr = 32'h27BDFFFC; q.push_back(u);
      u.idx = 2; u.last = 1; u.instr = {6'b000010, ins[25:0]}; q.push_back(u);
    end else if (op == 6'b111101 || op == 6'b111110) begin
      cnt = int'(ins[10:6]);
      n   = (cnt > 8) ? 8 : cnt;
      if (n == 0) begin
        u.idx = 0; u.last = 1; u.instr = 32'h0; q.push_back(u);
      end else begin
        for (int i = 0; i < n; i++) begin
          u.idx   = 5'(i);
          u.last  = (i == n - 1);
          u.instr = {(op == 6'b111101) ? 6'b100011 : 6'b101011, ins[25:21],
                     5'((int'(ins[20:16]) + i) % 32), 16'(4 * i)};
          q.push_back(u);
        end
      end
    end else begin
      u.idx = 0; u.last = 1; u.instr = ins; q.push_back(u);
    end
  endfunction

  task automatic compare_outputs();
    if (q.size() > 0) begin
      chk("uop_valid", 32'(uop_valid), 32'd1);
      chk("uop_instr", uop_instr, q[0].instr);
      chk("uop_pc",    uop_pc,    q[0].pc);
      chk("uop_idx",   32'(uop_idx),  32'(q[0].idx));
      chk("uop_last",  32'(uop_last), 32'(q[0].last));
    end else begin
      chk("uop_valid_idle", 32'(uop_valid), 32'd0);
    end
  endtask

  // One clock: drive at negedge, check in_ready, update model at posedge,
  // check outputs at the following negedge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic rdy, input logic fl);
    logic exp_ir;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    uop_ready = rdy;
    flush     = fl;
    #1;
    exp_ir  = !fl && (q.size() == 0 || (rdy && q[0].last));
    last_ir = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (v && exp_ir) expand(ins, pc);
    end
    @(negedge clk);
    compare_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    case ($urandom_range(0, 3))
      0: w = {6'b111100, 26'($urandom)};
      1: w = {6'b111101, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom_range(0, 31)), 6'($urandom)};
      2: w = {6'b111110, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom_range(0, 12)), 6'($urandom)};
      default: begin
        w = $urandom;
        if (w[31:26] >= 6'b111100 && w[31:26] <= 6'b111110) w[31:30] = 2'b00;
      end
    endcase
    return w;
  endfunction

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; uop_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    @(negedge clk);
    chk("rst_valid", 32'(uop_valid), 32'd0);
    chk("rst_instr", uop_instr, 32'd0);
    chk("rst_pc",    uop_pc,    32'd0);
    chk("rst_idx",   32'(uop_idx), 32'd0);
    chk("rst_last",  32'(uop_last), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Pass-through followed immediately by jap (zero-bubble handover).
    step(1, 32'h00221821, 32'h3000, 1, 0);
    chk("pass_instr", uop_instr, 32'h00221821);
    chk("pass_idx",   32'(uop_idx), 32'd0);
    chk("pass_last",  32'(uop_last), 32'd1);
    step(1, 32'hF0000100, 32'h3004, 1, 0);
    chk("pass_ready", 32'(last_ir), 32'd1);
    chk("jap_i0", uop_instr, 32'hAFBF0000);
    step(1, 32'h00000000, 32'h3008, 1, 0);
    chk("jap_busy_ready", 32'(last_ir), 32'd0);
    chk("jap_i1", uop_instr, 32'h27BDFFFC);
    for (int k = 0; k < 4; k++) begin
      step(0, 32'h0, 32'h0, 0, 0);
      chk("bp_instr", uop_instr, 32'h27BDFFFC);
      chk("bp_idx",   32'(uop_idx), 32'd1);
    end
    step(0, 32'h0, 32'h0, 1, 0);
    chk("jap_i2",   uop_instr, 32'h08000100);
    chk("jap_last", 32'(uop_last), 32'd1);
    chk("jap_pc",   uop_pc, 32'h3004);
    step(0, 32'h0, 32'h0, 1, 0);

    // lwm with register wrap.
    step(1, 32'hF49E00C0, 32'h4000, 1, 0);
    chk("lwm_i0", uop_instr, 32'h8C9E0000);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("lwm_i1", uop_instr, 32'h8C9F0004);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("lwm_i2", uop_instr, 32'h8C800008);
    chk("lwm_last", 32'(uop_last), 32'd1);
    step(0, 32'h0, 32'h0, 1, 0);

    // Clamp: cnt=20 gives exactly 8 micro-ops.
    begin
      int n;
      n = 0;
      step(1, {6'b111101, 5'd4, 5'd1, 5'd0, 5'd20, 6'd0}, 32'h5000, 1, 0);
      n = 1;
      while (!uop_last && n < 40) begin
        step(0, 32'h0, 32'h0, 1, 0);
        n++;
      end
      chk("clamp_count", 32'(n), 32'd8);
      chk("clamp_lastword", uop_instr, {6'b100011, 5'd4, 5'd8, 16'd28});
      step(0, 32'h0, 32'h0, 1, 0);
    end

    // Flush at swm i2 of 5.
    step(1, {6'b111110, 5'd2, 5'd10, 5'd0, 5'd5, 6'd0}, 32'h6000, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    chk("swm_i2", uop_instr, {6'b101011, 5'd2, 5'd12, 16'd8});
    step(1, 32'h00221821, 32'h6004, 1, 1);
    chk("flush_ready", 32'(last_ir), 32'd0);
    chk("flush_valid", 32'(uop_valid), 32'd0);
    step(1, 32'hF0000200, 32'h7000, 1, 0);
    chk("post_flush_idx", 32'(uop_idx), 32'd0);
    chk("post_flush_i0",  uop_instr, 32'hAFBF0000);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);

    // cnt=0 yields one nop.
    step(1, {6'b111101, 5'd3, 5'd5, 5'd0, 5'd0, 6'd0}, 32'h8000, 1, 0);
    chk("nop_instr", uop_instr, 32'h0);
    chk("nop_last",  32'(uop_last), 32'd1);
    step(0, 32'h0, 32'h0, 1, 0);

    // Asynchronous reset in the middle of an lwm.
    step(1, {6'b111101, 5'd6, 5'd7, 5'd0, 5'd5, 6'd0}, 32'h9000, 1, 0);
    step(0, 32'h0, 32'h0, 1, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 32'(uop_valid), 32'd0);
    chk("arst_instr", uop_instr, 32'd0);
    chk("arst_pc",    uop_pc, 32'd0);
    chk("arst_idx",   32'(uop_idx), 32'd0);
    q.delete();
    @(negedge clk);
    reset = 1'b1;
    compare_outputs();

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) < 60), rand_instr(), $urandom,
           ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
